// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_R, EX_I, WB_R, WB_I,
        MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;
    localparam logic [2:0] ALU_LUI = 3'd4;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and datapath (slave).
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       err;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
               mem_to_reg, ext_op, alu_src_a, alu_src_b, alu_op, err
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
               mem_to_reg, ext_op, alu_src_a, alu_src_b, alu_op, err
    );
endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct field to ALU operation; flags any funct outside the supported subset.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o,
    output logic       illegal_o
);

    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (funct_i)
            FN_ADDU: alu_op_o = ALU_ADD;
            FN_SUBU: alu_op_o = ALU_SUB;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: sequences one instruction through fetch/decode/execute/memory/write-back
// with a bounded memory-ready wait.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input logic        clk,
    input logic        rst_n,
    mc_ctrl_if.master  bus
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   waitCnt_q, waitCnt_d;
    logic [5:0]      opLat_q, opLat_d;
    logic [5:0]      functLat_q, functLat_d;
    logic            err_q, err_d;

    logic [5:0]      decFunct;
    logic [2:0]      rAluOp;
    logic            rIllegal;
    logic            waitState;
    logic            timeout;

    logic            pcWr, irWr, iOrD, memRd, memWr, regWr, regDst, memToReg, aluSrcA;
    logic [1:0]      pcSrc, extOp, aluSrcB;
    logic [2:0]      aluOp;

    // DECODE dispatches on the live funct; later states use the latched copy
    assign decFunct = (state_q == DECODE) ? bus.funct : functLat_q;

    mc_alu_dec u_alu_dec (
        .funct_i   (decFunct),
        .alu_op_o  (rAluOp),
        .illegal_o (rIllegal)
    );

    assign waitState = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout   = waitState && !bus.mem_ready && (waitCnt_q == CW'(MEM_WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            waitCnt_q  <= '0;
            opLat_q    <= '0;
            functLat_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            opLat_q    <= opLat_d;
            functLat_q <= functLat_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opLat_d    = opLat_q;
        functLat_d = functLat_q;
        err_d      = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) state_d = DECODE;
                else if (timeout) err_d = 1'b1;
            end
            DECODE: begin
                opLat_d    = bus.op;
                functLat_d = bus.funct;
                case (bus.op)
                    OP_RTYPE: begin
                        if (rIllegal) begin
                            state_d = FETCH;
                            err_d   = 1'b1;
                        end else begin
                            state_d = EX_R;
                        end
                    end
                    OP_ORI, OP_ADDIU, OP_LUI: state_d = EX_I;
                    OP_LW, OP_SW:             state_d = MEM_ADDR;
                    OP_BEQ:                   state_d = BRANCH;
                    OP_J:                     state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        err_d   = 1'b1;
                    end
                endcase
            end
            EX_R:     state_d = WB_R;
            EX_I:     state_d = WB_I;
            MEM_ADDR: state_d = (opLat_q == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (bus.mem_ready) state_d = MEM_WB;
                else if (timeout) begin
                    state_d = FETCH;
                    err_d   = 1'b1;
                end
            end
            MEM_WR: begin
                if (bus.mem_ready) state_d = FETCH;
                else if (timeout) begin
                    state_d = FETCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase
        // Restart the wait budget whenever a new state (or a fresh fetch after timeout) begins
        waitCnt_d = ((state_d != state_q) || timeout) ? '0 : waitCnt_q + CW'(1);
    end

    always_comb begin
        pcWr     = 1'b0;
        pcSrc    = PC_SEQ;
        irWr     = 1'b0;
        iOrD     = 1'b0;
        memRd    = 1'b0;
        memWr    = 1'b0;
        regWr    = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        extOp    = EXT_ZERO;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_RT;
        aluOp    = ALU_ADD;
        if (!rst_n) begin
            aluSrcB = SRCB_FOUR;
        end else begin
            case (state_q)
                FETCH: begin
                    memRd   = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWr    = bus.mem_ready;
                    pcWr    = bus.mem_ready;
                end
                DECODE: begin
                    extOp   = EXT_SIGN;
                    aluSrcB = SRCB_IMM_SH;
                end
                EX_R: begin
                    aluSrcA = 1'b1;
                    aluOp   = rAluOp;
                end
                EX_I: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                    case (opLat_q)
                        OP_ORI:  aluOp = ALU_OR;
                        OP_LUI:  aluOp = ALU_LUI;
                        default: extOp = EXT_SIGN;
                    endcase
                end
                WB_R: begin
                    regWr  = 1'b1;
                    regDst = 1'b1;
                end
                WB_I: regWr = 1'b1;
                MEM_ADDR: begin
                    extOp   = EXT_SIGN;
                    aluSrcB = SRCB_IMM;
                end
                MEM_RD: begin
                    memRd = 1'b1;
                    iOrD  = 1'b1;
                end
                MEM_WB: begin
                    regWr    = 1'b1;
                    memToReg = 1'b1;
                end
                MEM_WR: begin
                    memWr = 1'b1;
                    iOrD  = 1'b1;
                end
                BRANCH: begin
                    aluSrcA = 1'b1;
                    aluOp   = ALU_SUB;
                    pcWr    = bus.zero;
                    pcSrc   = PC_BR;
                end
                JUMP: begin
                    pcWr  = 1'b1;
                    pcSrc = PC_JMP;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_wr      = pcWr;
    assign bus.pc_src     = pcSrc;
    assign bus.ir_wr      = irWr;
    assign bus.i_or_d     = iOrD;
    assign bus.mem_rd     = memRd;
    assign bus.mem_wr     = memWr;
    assign bus.reg_wr     = regWr;
    assign bus.reg_dst    = regDst;
    assign bus.mem_to_reg = memToReg;
    assign bus.ext_op     = extOp;
    assign bus.alu_src_a  = aluSrcA;
    assign bus.alu_src_b  = aluSrcB;
    assign bus.alu_op     = aluOp;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and checks
// state plus every control output against hand-derived vectors.
module tb_mc_ctrl;
    import mc_pkg::*;

    typedef struct packed {
        logic       pcWr;
        logic [1:0] pcSrc;
        logic       irWr;
        logic       iOrD;
        logic       memRd;
        logic       memWr;
        logic       regWr;
        logic       regDst;
        logic       memToReg;
        logic [1:0] extOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       err;
    } ctl_t;

    localparam logic [5:0] JUNK = 6'h3f;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mc_ctrl_if bus ();

    mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t vReset();
        ctl_t v = '0;
        v.aluSrcB = 2'b01;
        return v;
    endfunction

    function automatic ctl_t vFetch(input logic rdy, input logic e);
        ctl_t v = '0;
        v.memRd   = 1'b1;
        v.aluSrcB = 2'b01;
        v.irWr    = rdy;
        v.pcWr    = rdy;
        v.err     = e;
        return v;
    endfunction

    function automatic ctl_t vDecode();
        ctl_t v = '0;
        v.extOp   = 2'b01;
        v.aluSrcB = 2'b11;
        return v;
    endfunction

    function automatic ctl_t vExR(input logic [2:0] op);
        ctl_t v = '0;
        v.aluSrcA = 1'b1;
        v.aluOp   = op;
        return v;
    endfunction

    function automatic ctl_t vExI(input logic [1:0] ext, input logic [2:0] op);
        ctl_t v = '0;
        v.aluSrcA = 1'b1;
        v.aluSrcB = 2'b10;
        v.extOp   = ext;
        v.aluOp   = op;
        return v;
    endfunction

    function automatic ctl_t vWb(input logic dst, input logic m2r);
        ctl_t v = '0;
        v.regWr    = 1'b1;
        v.regDst   = dst;
        v.memToReg = m2r;
        return v;
    endfunction

    function automatic ctl_t vMemAddr();
        ctl_t v = '0;
        v.extOp   = 2'b01;
        v.aluSrcB = 2'b10;
        return v;
    endfunction

    function automatic ctl_t vMemAcc(input logic wr);
        ctl_t v = '0;
        v.memRd = !wr;
        v.memWr = wr;
        v.iOrD  = 1'b1;
        return v;
    endfunction

    function automatic ctl_t vBranch(input logic z);
        ctl_t v = '0;
        v.aluSrcA = 1'b1;
        v.aluOp   = 3'd1;
        v.pcWr    = z;
        v.pcSrc   = 2'b01;
        return v;
    endfunction

    function automatic ctl_t vJump();
        ctl_t v = '0;
        v.pcWr  = 1'b1;
        v.pcSrc = 2'b10;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic r);
        @(negedge clk);
        rst_n         = rst;
        bus.op        = o;
        bus.funct     = f;
        bus.zero      = z;
        bus.mem_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input state_t s, input ctl_t v);
        ctl_t a;
        a = {bus.pc_wr, bus.pc_src, bus.ir_wr, bus.i_or_d, bus.mem_rd, bus.mem_wr,
             bus.reg_wr, bus.reg_dst, bus.mem_to_reg, bus.ext_op, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.err};
        checks++;
        assert (dut.state_q === s) else begin
            failures++;
            $error("[TB] FAIL %s state: got %0d expected %0d", tag, dut.state_q, s);
        end
        checks++;
        assert (a === v) else begin
            failures++;
            $error("[TB] FAIL %s ctl: got %05h expected %05h", tag, a, v);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // reset: mem_ready high must not leak into ir_wr/pc_wr or mem_rd
        applyStimulus(0, 6'h00, 6'h00, 0, 1); checkOutput("reset", FETCH, vReset());

        // addu
        applyStimulus(1, OP_RTYPE, FN_ADDU, 0, 1); checkOutput("addu_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_RTYPE, FN_ADDU, 0, 1); checkOutput("addu_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("addu_c3", EX_R, vExR(ALU_ADD));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("addu_c4", WB_R, vWb(1, 0));

        // slt
        applyStimulus(1, OP_RTYPE, FN_SLT, 0, 1);  checkOutput("slt_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_RTYPE, FN_SLT, 0, 1);  checkOutput("slt_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("slt_c3", EX_R, vExR(ALU_SLT));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("slt_c4", WB_R, vWb(1, 0));

        // ori
        applyStimulus(1, OP_ORI, 6'h00, 0, 1);     checkOutput("ori_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_ORI, 6'h00, 0, 1);     checkOutput("ori_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("ori_c3", EX_I, vExI(EXT_ZERO, ALU_OR));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("ori_c4", WB_I, vWb(0, 0));

        // addiu
        applyStimulus(1, OP_ADDIU, 6'h00, 0, 1);   checkOutput("addiu_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_ADDIU, 6'h00, 0, 1);   checkOutput("addiu_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("addiu_c3", EX_I, vExI(EXT_SIGN, ALU_ADD));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("addiu_c4", WB_I, vWb(0, 0));

        // lui
        applyStimulus(1, OP_LUI, 6'h00, 0, 1);     checkOutput("lui_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_LUI, 6'h00, 0, 1);     checkOutput("lui_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("lui_c3", EX_I, vExI(EXT_ZERO, ALU_LUI));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("lui_c4", WB_I, vWb(0, 0));

        // lw with three not-ready cycles in MEM_RD: 8 cycles total
        applyStimulus(1, OP_LW, 6'h00, 0, 1);      checkOutput("lw_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_LW, 6'h00, 0, 1);      checkOutput("lw_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("lw_c3", MEM_ADDR, vMemAddr());
        applyStimulus(1, JUNK, JUNK, 0, 0);        checkOutput("lw_c4", MEM_RD, vMemAcc(0));
        applyStimulus(1, JUNK, JUNK, 0, 0);        checkOutput("lw_c5", MEM_RD, vMemAcc(0));
        applyStimulus(1, JUNK, JUNK, 0, 0);        checkOutput("lw_c6", MEM_RD, vMemAcc(0));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("lw_c7", MEM_RD, vMemAcc(0));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("lw_c8", MEM_WB, vWb(0, 1));

        // beq taken
        applyStimulus(1, OP_BEQ, 6'h00, 1, 1);     checkOutput("beq1_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_BEQ, 6'h00, 1, 1);     checkOutput("beq1_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 1, 1);        checkOutput("beq1_c3", BRANCH, vBranch(1));

        // beq not taken; following FETCH belongs to the jump below
        applyStimulus(1, OP_BEQ, 6'h00, 0, 1);     checkOutput("beq0_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_BEQ, 6'h00, 0, 1);     checkOutput("beq0_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("beq0_c3", BRANCH, vBranch(0));

        // j
        applyStimulus(1, OP_J, 6'h00, 0, 1);       checkOutput("j_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_J, 6'h00, 0, 1);       checkOutput("j_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("j_c3", JUMP, vJump());

        // illegal opcode: err one cycle after DECODE, no writes
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("ill_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("ill_c2", DECODE, vDecode());
        applyStimulus(1, 6'h00, 6'h00, 0, 0);      checkOutput("ill_c3", FETCH, vFetch(0, 1));
        applyStimulus(1, 6'h00, 6'h00, 0, 0);      checkOutput("ill_c4", FETCH, vFetch(0, 0));

        // illegal R-type funct
        applyStimulus(1, OP_RTYPE, 6'h00, 0, 1);   checkOutput("illf_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_RTYPE, 6'h00, 0, 1);   checkOutput("illf_c2", DECODE, vDecode());
        applyStimulus(1, 6'h00, 6'h00, 0, 0);      checkOutput("illf_c3", FETCH, vFetch(0, 1));

        // sw, zero wait: 4 cycles
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("sw_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("sw_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("sw_c3", MEM_ADDR, vMemAddr());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("sw_c4", MEM_WR, vMemAcc(1));

        // sw timeout: 16 not-ready cycles in MEM_WR, then err in FETCH
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("swto_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("swto_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("swto_c3", MEM_ADDR, vMemAddr());
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, JUNK, JUNK, 0, 0);    checkOutput($sformatf("swto_w%0d", i), MEM_WR, vMemAcc(1));
        end
        applyStimulus(1, JUNK, JUNK, 0, 0);        checkOutput("swto_err", FETCH, vFetch(0, 1));

        // asynchronous reset in the middle of MEM_WR
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("rst_c1", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_SW, 6'h00, 0, 1);      checkOutput("rst_c2", DECODE, vDecode());
        applyStimulus(1, JUNK, JUNK, 0, 1);        checkOutput("rst_c3", MEM_ADDR, vMemAddr());
        applyStimulus(1, JUNK, JUNK, 0, 0);        checkOutput("rst_c4", MEM_WR, vMemAcc(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", FETCH, vReset());
        applyStimulus(0, JUNK, JUNK, 0, 1);        checkOutput("rst_hold", FETCH, vReset());
        applyStimulus(1, OP_J, 6'h00, 0, 1);       checkOutput("rst_rel", FETCH, vFetch(1, 0));
        applyStimulus(1, OP_J, 6'h00, 0, 1);       checkOutput("rst_dec", DECODE, vDecode());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
